// File: rtl/riscv_pkg.sv
// Shared RV32I constants: word type, NOP encoding and the boot program image
// that the instruction ROM serves from word 0 upward.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] instr_t;

   // addi x0,x0,0
   localparam instr_t NOP_WORD = 32'h00000013;

   localparam int BOOT_LEN = 6;

   localparam instr_t BOOT_PROG [BOOT_LEN] = '{
      32'h00500093,   // addi x1,x0,5
      32'h00A00113,   // addi x2,x0,10
      32'h002081B3,   // add  x3,x1,x2
      32'h40110233,   // sub  x4,x2,x1
      32'h0041F2B3,   // and  x5,x3,x4
      32'h0000006F    // jal  x0,0 (spin)
   };

endpackage

// File: rtl/instruction_rom.sv
// Combinational boot ROM: word index -> instruction word. Anything outside
// the boot image, including indices past DEPTH, reads as NOP_WORD.
module instruction_rom
   import riscv_pkg::*;
#(
   parameter int     DEPTH    = 256,
   parameter instr_t NOP_WORD = riscv_pkg::NOP_WORD
) (
   input  logic [XLEN-1:0] i_index,
   output logic [XLEN-1:0] o_word
);

   always_comb begin
      o_word = NOP_WORD;
      // No wrap-around: high indices must not alias onto the boot image.
      if (i_index < 32'(DEPTH)) begin
         for (int k = 0; k < BOOT_LEN; k++) begin
            if (i_index == 32'(k)) begin
               o_word = BOOT_PROG[k];
            end
         end
      end
   end

endmodule

// File: rtl/instruction_mem.sv
// Fetch-stage instruction memory: registered read of the boot ROM, one cycle
// of latency, synchronous active-high reset forcing the output to NOP.
module instruction_mem
   import riscv_pkg::*;
#(
   parameter int     DEPTH    = 256,
   parameter instr_t NOP_WORD = riscv_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] io_addr,
   output logic [31:0] io_data
);

   logic [XLEN-1:0] w_index;
   logic [XLEN-1:0] w_rom_word;
   logic [XLEN-1:0] r_data = NOP_WORD;

   // Byte address to word index; the low two bits drop out, so a misaligned
   // address reads the containing word.
   assign w_index = io_addr >> 2;

   instruction_rom #(
      .DEPTH    (DEPTH),
      .NOP_WORD (NOP_WORD)
   ) u_rom (
      .i_index (w_index),
      .o_word  (w_rom_word)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data <= NOP_WORD;
      end else begin
         r_data <= w_rom_word;
      end
   end

   assign io_data = r_data;

endmodule

// File: tb/tb_instruction_mem.sv
// Directed bench for instruction_mem: reset, sequential fetch, misalignment,
// out-of-range reads, mid-cycle address changes and reset mid-stream.
module tb_instruction_mem;

   logic        clk;
   logic        reset;
   logic [31:0] io_addr;
   logic [31:0] io_data;

   int n_chk;
   int n_err;

   localparam logic [31:0] NOP = 32'h00000013;

   instruction_mem #(
      .DEPTH    (256),
      .NOP_WORD (32'h00000013)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .io_addr (io_addr),
      .io_data (io_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Present inputs, take one rising edge, check the registered output.
   task automatic cyc(input logic [31:0] a, input logic r, input logic [31:0] exp,
                      input string tag);
      io_addr = a;
      reset   = r;
      @(posedge clk);
      #1;
      chk(tag, io_data, exp);
   endtask

   initial begin
      n_chk   = 0;
      n_err   = 0;
      reset   = 1'b1;
      io_addr = 32'h0;

      #1;
      chk("initial", io_data, NOP);

      cyc(32'h0, 1'b1, NOP, "reset_0");
      cyc(32'h0, 1'b1, NOP, "reset_1");
      cyc(32'h0, 1'b0, 32'h00500093, "first_read");

      cyc(32'h00, 1'b0, 32'h00500093, "seq_w0");
      cyc(32'h04, 1'b0, 32'h00A00113, "seq_w1");
      cyc(32'h08, 1'b0, 32'h002081B3, "seq_w2");
      cyc(32'h0C, 1'b0, 32'h40110233, "seq_w3");
      cyc(32'h10, 1'b0, 32'h0041F2B3, "seq_w4");
      cyc(32'h14, 1'b0, 32'h0000006F, "seq_w5");

      cyc(32'h09, 1'b0, 32'h002081B3, "misalign_9");
      cyc(32'h07, 1'b0, 32'h00A00113, "misalign_7");
      cyc(32'h13, 1'b0, 32'h0041F2B3, "misalign_13");

      cyc(32'h18,       1'b0, NOP, "unused_w6");
      cyc(32'h3FC,      1'b0, NOP, "last_in_range");
      cyc(32'h400,      1'b0, NOP, "oor_depth");
      cyc(32'h404,      1'b0, NOP, "oor_alias_w1");
      cyc(32'hFFFFFFFC, 1'b0, NOP, "oor_top");

      // Address change between edges must not disturb the held output.
      cyc(32'h0, 1'b0, 32'h00500093, "stable_pre");
      #3;
      io_addr = 32'h4;
      #1;
      chk("stable_mid", io_data, 32'h00500093);
      @(posedge clk);
      #1;
      chk("stable_post", io_data, 32'h00A00113);

      cyc(32'h00, 1'b0, 32'h00500093, "mid_w0");
      cyc(32'h04, 1'b0, 32'h00A00113, "mid_w1");
      cyc(32'h08, 1'b1, NOP,          "mid_reset");
      cyc(32'h0C, 1'b0, 32'h40110233, "mid_release");
      cyc(32'h14, 1'b1, NOP,          "reset_prio");
      cyc(32'h14, 1'b0, 32'h0000006F, "after_prio");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
